fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline. Drives the 3-bit source-select codes of the EX-stage ALU operand muxes, and the load-use stall/bubble signals.
- Keeps a shadow scoreboard of the EX, MEM and WB destination registers.
- Select codes are registered at the ID→EX transfer, so they are aligned with the instruction in EX.

Parameters:
- REG_ADDR_W, 5, register index width; index 0 is hard-wired zero and never forwards or stalls.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (memory wait); no stage advances.
- flush  in  1  branch/jump redirect; kills the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices.
- id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2 as an ALU operand.
- id_use_imm  in  1  ALU operand 2 is the immediate.
- id_rd  in  REG_ADDR_W  destination index.
- id_regwrite  in  1  instruction writes rd.
- id_memread  in  1  instruction is a load.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_bubble  out  1  registered; EX holds an inserted bubble.
- src1_sel  out  3  registered operand-1 select for EX.
- src2_sel  out  3  registered operand-2 select for EX.

Behaviour:
- Select encoding:
  - 3'b100 = register-file value.
  - 3'b110 = MEM-stage forward.
  - 3'b101 = WB-stage forward.
  - 3'b000 = immediate (src2 only).
  - No other codes are ever driven.
- Internal records EX/MEM/WB each hold {valid, rd, regwrite, memread}. A record "writes r" when valid && regwrite && rd==r && r!=0.
- Load-use hazard (combinational):
  - Condition: id_valid && EX.valid && EX.memread && EX writes a source register that ID uses (rs1 with id_use_rs1, or rs2 with id_use_rs2 && !id_use_imm).
  - stall = hazard && !flush && !hold.
- Advance on each edge, when !hold:
  - MEM→WB and EX→MEM always advance.
  - If stall or flush, or !id_valid: EX is loaded with an invalid bubble, ex_bubble=1, src1_sel=3'b100, src2_sel=3'b100.
  - Otherwise EX is loaded from the ID inputs, ex_bubble=0, and the selects are computed against the current EX record (which becomes MEM) and the current MEM record (which becomes WB).
  - srcN_sel=3'b110 if the current EX record writes rsN; else 3'b101 if the current MEM record writes rsN; else 3'b100. MEM forward has priority when both match.
  - If id_use_rs1=0, src1_sel=3'b100.
  - If id_use_imm=1, src2_sel=3'b000, regardless of rs2 matches.
- When hold=1: all records and outputs keep their values; stall=0.
- Priority: hold > flush > stall.
- Stall length: exactly 1 cycle per load-use. After the bubble, the load sits in MEM and advances to WB as the dependent instruction enters EX, so the dependent gets 3'b101.
- Back-to-back: a load followed by two dependents gives one stall only. The second dependent is 2 stages behind and gets 3'b101 or register.
- Reset (RST=1 at edge): all records invalid, ex_bubble=1, src1_sel=src2_sel=3'b100, counter=0. stall=0 while RST=1. Reset mid-stall discards the stall.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0] and output fwd_cnt [31:0].
  - stall_cnt increments on every edge where stall=1; fwd_cnt increments on every non-hold advance that loads a forward code (3'b110/3'b101) into either select, by 1 per instruction.
  - Both counters wrap at 2^32 and clear on RST.
- When undefined: neither port exists, and no counter logic is present.

Test Plan:
- ADD x5 then ADD x6,x5,x7 back-to-back → second in EX with src1_sel=3'b110, src2_sel=3'b100, stall never 1.
- ADD x5; NOP; SUB x8,x1,x5 → SUB in EX with src2_sel=3'b101.
- LW x5 then ADD x6,x5,x5 → stall=1 for exactly one cycle, ex_bubble=1 next cycle, then ADD in EX with src1_sel=src2_sel=3'b101.
- LW x5 then ADDI x6,x0,5 with id_use_imm=1, rs2 field=5 → no stall, src2_sel=3'b000.
- Writes to x0 (ADD x0 then ADD x1,x0,x0) → selects 3'b100, no stall. LW x5 + dependent with flush=1 → stall=0, bubble inserted.
- hold=1 for 3 cycles during a load-use hazard → outputs frozen, stall=0; after release, exactly one stall cycle. RST asserted mid-sequence → next cycle selects 3'b100, ex_bubble=1, stall_cnt=0 (with HAZ_PERF_CNT_EN).

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Groups the ID-stage request signals and the controller's forwarding/stall
// responses for the 5-stage pipeline forwarding and hazard controller.
//
//   master : pipeline side (drives ID-stage info, consumes stall/selects)
//   slave  : controller side (fwd_hazard_ctrl)
//
// Signals
//   hold, flush                 pipeline freeze / redirect
//   id_valid                    ID holds a real instruction
//   id_rs1, id_rs2              source register indices
//   id_use_rs1, id_use_rs2      instruction reads rs1 / rs2 as ALU operand
//   id_use_imm                  ALU operand 2 is the immediate
//   id_rd, id_regwrite          destination index and write enable
//   id_memread                  instruction is a load
//   stall                       combinational: hold PC and IF/ID
//   ex_bubble                   registered: EX holds an inserted bubble
//   src1_sel, src2_sel          registered EX operand select codes
// -----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  hold;
  logic                  flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  id_use_imm;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  stall;
  logic                  ex_bubble;
  logic [2:0]            src1_sel;
  logic [2:0]            src2_sel;

  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_use_imm, id_rd, id_regwrite, id_memread,
    input  stall, ex_bubble, src1_sel, src2_sel
  );

  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_use_imm, id_rd, id_regwrite, id_memread,
    output stall, ex_bubble, src1_sel, src2_sel
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks a shadow scoreboard of in-flight destination registers and, at the
// ID->EX transfer, registers the EX operand source-select codes:
//   3'b100 register file, 3'b110 MEM forward, 3'b101 WB forward,
//   3'b000 immediate (operand 2 only).
// A load in EX whose destination is read by the ID instruction raises a
// one-cycle combinational stall and a bubble is inserted into EX.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   bus        fwd_hazard_ctrl_if.slave (ID request, stall/bubble/selects)
//   stall_cnt  [31:0] edges with stall=1          (HAZ_PERF_CNT_EN only)
//   fwd_cnt    [31:0] instructions given a forward (HAZ_PERF_CNT_EN only)
//
// Build option
//   HAZ_PERF_CNT_EN : adds the stall_cnt / fwd_cnt performance counters.
//
// The WB record is not stored: the selects are decided one stage early, so
// the records that matter are the ones currently in EX (moving to MEM) and
// MEM (moving to WB). Likewise only the EX record needs the load flag.
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  fwd_hazard_ctrl_if.slave   bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        fwd_cnt
`endif
);

  localparam logic [2:0] SEL_IMM = 3'b000;
  localparam logic [2:0] SEL_REG = 3'b100;
  localparam logic [2:0] SEL_WB  = 3'b101;
  localparam logic [2:0] SEL_MEM = 3'b110;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } rec_t;

  // True when record r will write register idx (x0 never counts).
  function automatic logic rec_writes(rec_t r, logic [REG_ADDR_W-1:0] idx);
    return r.valid && r.regwrite && (r.rd == idx) && (idx != '0);
  endfunction

  // Operand select against the records about to become MEM and WB.
  // The younger producer (current EX) wins over the older one.
  function automatic logic [2:0] fwd_sel(logic used, logic [REG_ADDR_W-1:0] idx,
                                         rec_t ex_r, rec_t mem_r);
    if (!used)                       return SEL_REG;
    else if (rec_writes(ex_r, idx))  return SEL_MEM;
    else if (rec_writes(mem_r, idx)) return SEL_WB;
    else                             return SEL_REG;
  endfunction

  rec_t       ex_q, ex_d;
  logic       ex_memread_q, ex_memread_d;
  rec_t       mem_q;
  logic       bubble_q, bubble_d;
  logic [2:0] sel1_q, sel1_d;
  logic [2:0] sel2_q, sel2_d;
  logic       hazard;
  logic       load_bubble;

  // Load-use: the load in EX cannot forward its data in time for ID.
  assign hazard = bus.id_valid && ex_q.valid && ex_memread_q &&
                  ((bus.id_use_rs1 && rec_writes(ex_q, bus.id_rs1)) ||
                   (bus.id_use_rs2 && !bus.id_use_imm && rec_writes(ex_q, bus.id_rs2)));

  // hold outranks flush, which outranks the stall; reset suppresses it too.
  assign bus.stall   = hazard && !bus.flush && !bus.hold && !RST;
  assign load_bubble = bus.stall || bus.flush || !bus.id_valid;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ex_d         = '0;
    ex_memread_d = 1'b0;
    bubble_d     = 1'b1;
    sel1_d       = SEL_REG;
    sel2_d       = SEL_REG;
    if (!load_bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = bus.id_rd;
      ex_d.regwrite = bus.id_regwrite;
      ex_memread_d  = bus.id_memread;
      bubble_d      = 1'b0;
      sel1_d        = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
      sel2_d        = bus.id_use_imm ? SEL_IMM
                                     : fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
    end
  end

  // NOTE: reset is synchronous here, sampled only at the clock edge, so RST
  // sits inside the edge-triggered branch rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q         <= '0;
      ex_memread_q <= 1'b0;
      mem_q        <= '0;
      bubble_q     <= 1'b1;
      sel1_q       <= SEL_REG;
      sel2_q       <= SEL_REG;
    end else if (!bus.hold) begin
      // NOTE: non-blocking assignments let mem_q capture the old ex_q in the
      // same edge that ex_q takes its new value.
      mem_q        <= ex_q;
      ex_q         <= ex_d;
      ex_memread_q <= ex_memread_d;
      bubble_q     <= bubble_d;
      sel1_q       <= sel1_d;
      sel2_q       <= sel2_d;
    end
  end

  assign bus.ex_bubble = bubble_q;
  assign bus.src1_sel  = sel1_q;
  assign bus.src2_sel  = sel2_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;
  logic        fwd_loaded;

  // One count per instruction even if both operands forward.
  assign fwd_loaded = !bus.hold && !load_bubble &&
                      (sel1_d == SEL_MEM || sel1_d == SEL_WB ||
                       sel2_d == SEL_MEM || sel2_d == SEL_WB);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (bus.stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (fwd_loaded) fwd_cnt_q  <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Self-checking bench for fwd_hazard_ctrl. A reference model keeps the last
// two instructions issued into EX as a queue (index 0 = now in EX) and
// derives stall, bubble and select codes from the forwarding rules directly.
// Honours HAZ_PERF_CNT_EN for the performance counters.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;
  localparam int W = 5;

  logic CLK;
  logic RST;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  fwd_hazard_ctrl_if #(.REG_ADDR_W(W)) bus ();

  fwd_hazard_ctrl #(.REG_ADDR_W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2; bit imm; int rd; bit rw; bit ld;
  } ins_t;

  typedef struct {
    bit valid; int rd; bit rw; bit ld;
  } minst_t;

  minst_t pipe[$];
  logic [2:0]  exp_s1, exp_s2;
  logic        exp_bub;
  logic [31:0] exp_stall_cnt, exp_fwd_cnt;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic ins_t mk(bit v, int rs1, int rs2, bit u1, bit u2, bit imm,
                              int rd, bit rw, bit ld);
    ins_t i;
    i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.imm = imm;
    i.rd = rd; i.rw = rw; i.ld = ld;
    return i;
  endfunction

  function automatic bit wr(minst_t m, int r);
    return m.valid && m.rw && m.rd == r && r != 0;
  endfunction

  // Nearest older producer: one ahead -> MEM forward, two ahead -> WB forward.
  function automatic logic [2:0] ref_sel(bit used, int r);
    if (!used) return 3'b100;
    for (int k = 0; k < pipe.size() && k < 2; k++)
      if (wr(pipe[k], r)) return (k == 0) ? 3'b110 : 3'b101;
    return 3'b100;
  endfunction

  function automatic bit ref_hazard(ins_t i);
    if (!i.v || pipe.size() == 0) return 0;
    if (!(pipe[0].valid && pipe[0].ld)) return 0;
    return (i.u1 && wr(pipe[0], i.rs1)) || (i.u2 && !i.imm && wr(pipe[0], i.rs2));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(ins_t i, bit h, bit f);
    bus.hold        = h;
    bus.flush       = f;
    bus.id_valid    = i.v;
    bus.id_rs1      = W'(i.rs1);
    bus.id_rs2      = W'(i.rs2);
    bus.id_use_rs1  = i.u1;
    bus.id_use_rs2  = i.u2;
    bus.id_use_imm  = i.imm;
    bus.id_rd       = W'(i.rd);
    bus.id_regwrite = i.rw;
    bus.id_memread  = i.ld;
  endtask

  task automatic check_regs(string tag);
    chk({tag, ":ex_bubble"}, 32'(bus.ex_bubble), 32'(exp_bub));
    chk({tag, ":src1_sel"},  32'(bus.src1_sel),  32'(exp_s1));
    chk({tag, ":src2_sel"},  32'(bus.src2_sel),  32'(exp_s2));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ":stall_cnt"}, stall_cnt, exp_stall_cnt);
    chk({tag, ":fwd_cnt"},   fwd_cnt,   exp_fwd_cnt);
`endif
  endtask

  // One clock: drive ID, check stall, advance model on the edge, check regs.
  task automatic step(string tag, ins_t i, bit h, bit f);
    bit exp_stall;
    minst_t m;
    drive(i, h, f);
    #2;
    exp_stall = ref_hazard(i) && !f && !h;
    chk({tag, ":stall"}, 32'(bus.stall), 32'(exp_stall));
    @(posedge CLK);
    if (!h) begin
      if (exp_stall || f || !i.v) begin
        m = '{valid: 0, rd: 0, rw: 0, ld: 0};
        exp_bub = 1; exp_s1 = 3'b100; exp_s2 = 3'b100;
      end else begin
        m = '{valid: 1, rd: i.rd, rw: i.rw, ld: i.ld};
        exp_bub = 0;
        exp_s1  = ref_sel(i.u1, i.rs1);
        exp_s2  = i.imm ? 3'b000 : ref_sel(i.u2, i.rs2);
        if (exp_s1 inside {3'b110, 3'b101} || exp_s2 inside {3'b110, 3'b101})
          exp_fwd_cnt++;
      end
      pipe.push_front(m);
      if (pipe.size() > 2) void'(pipe.pop_back());
    end
    if (exp_stall) exp_stall_cnt++;
    #1;
    check_regs(tag);
  endtask

  // Reset edge with a (possibly hazardous) instruction still presented in ID.
  task automatic do_reset(string tag, ins_t i);
    RST = 1'b1;
    drive(i, 1'b0, 1'b0);
    #2;
    chk({tag, ":stall_in_rst"}, 32'(bus.stall), 32'd0);
    @(posedge CLK);
    pipe.delete();
    exp_bub = 1; exp_s1 = 3'b100; exp_s2 = 3'b100;
    exp_stall_cnt = 0; exp_fwd_cnt = 0;
    #1;
    RST = 1'b0;
    check_regs(tag);
  endtask

  ins_t nop, add5, add6, sub8, lw5, dep5, addi, addx0, add1x0, lw7, dep7, r;

  initial begin
    RST = 1'b0;
    nop    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add5   = mk(1, 1, 2, 1, 1, 0, 5, 1, 0);
    add6   = mk(1, 5, 7, 1, 1, 0, 6, 1, 0);
    sub8   = mk(1, 1, 5, 1, 1, 0, 8, 1, 0);
    lw5    = mk(1, 3, 0, 1, 0, 1, 5, 1, 1);
    dep5   = mk(1, 5, 5, 1, 1, 0, 6, 1, 0);
    addi   = mk(1, 0, 5, 1, 1, 1, 6, 1, 0);
    addx0  = mk(1, 1, 2, 1, 1, 0, 0, 1, 0);
    add1x0 = mk(1, 0, 0, 1, 1, 0, 1, 1, 0);
    lw7    = mk(1, 2, 0, 1, 0, 1, 7, 1, 1);
    dep7   = mk(1, 4, 7, 1, 1, 0, 9, 1, 0);

    do_reset("reset0", nop);

    // Back-to-back ALU forward from MEM.
    step("add5", add5, 0, 0);
    step("add6_fwd_mem", add6, 0, 0);
    step("nop_a", nop, 0, 0);

    // One instruction gap: WB forward.
    step("add5_b", add5, 0, 0);
    step("nop_b", nop, 0, 0);
    step("sub8_fwd_wb", sub8, 0, 0);

    // Load-use: one stall, then both operands from WB.
    step("lw5", lw5, 0, 0);
    step("dep_stall", dep5, 0, 0);
    step("dep_go", dep5, 0, 0);
    step("nop_c", nop, 0, 0);

    // Load followed by immediate op: no stall, src2 immediate.
    step("lw5_imm", lw5, 0, 0);
    step("addi", addi, 0, 0);

    // x0 never forwards.
    step("addx0", addx0, 0, 0);
    step("add1x0", add1x0, 0, 0);

    // Flush beats load-use stall.
    step("lw5_fl", lw5, 0, 0);
    step("dep_flush", dep5, 0, 1);
    step("nop_d", nop, 0, 0);

    // Hold during a hazard freezes everything, then exactly one stall.
    step("lw5_h", lw5, 0, 0);
    for (int k = 0; k < 3; k++) step("dep_hold", dep5, 1, 0);
    step("dep_after_hold", dep5, 0, 0);
    step("dep_go_h", dep5, 0, 0);

    // Load then two dependents: single stall, second gets WB or register.
    step("lw7", lw7, 0, 0);
    step("dep7_a", dep7, 0, 0);
    step("dep7_a_go", dep7, 0, 0);
    step("dep7_b", dep7, 0, 0);

    // Reset in the middle of a load-use stall.
    step("lw5_r", lw5, 0, 0);
    step("dep_pre_rst", dep5, 0, 0);
    do_reset("reset_mid", dep5);
    step("dep_post_rst", dep5, 0, 0);

    // Randomised traffic over a small register range to force collisions.
    for (int n = 0; n < 400; n++) begin
      r.v   = ($urandom_range(0, 99) < 85);
      r.rs1 = $urandom_range(0, 7);
      r.rs2 = $urandom_range(0, 7);
      r.u1  = ($urandom_range(0, 9) != 0);
      r.imm = ($urandom_range(0, 3) == 0);
      r.u2  = r.imm ? 1'($urandom_range(0, 1)) : 1'b1;
      r.rd  = $urandom_range(0, 7);
      r.rw  = ($urandom_range(0, 9) != 0);
      r.ld  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 199) == 0)
        do_reset("rnd_reset", r);
      else
        step("rnd", r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
